// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, default PC constants
// and the PC advance helper.
package fetch_pkg;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;
  localparam logic [31:0] PC_STEP_DEF  = 32'd4;

  // Sequential fetch address; wraps naturally at 2^32.
  function automatic logic [31:0] pc_advance(input logic [31:0] pc,
                                             input logic [31:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {pc,inst} skid buffer behind the fetch output slot.
// Priority: flush over load over drain.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_flush,
  input  logic        i_load,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  input  logic        i_drain,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_inst;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_pc    <= 32'h0;
      r_inst  <= 32'h0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, runs the single-outstanding SRAM handshake and
// delivers {pc,inst} to ID. Optional performance counters under FETCH_PERF_CNT_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ds_allow_in,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        fs_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_cancel_cnt
`endif
);

  fetch_state_e r_state;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_inflight_pc;
  logic         r_cancel_pend;
  logic         r_fs_valid;
  logic [31:0]  r_fs_pc;
  logic [31:0]  r_fs_inst;

  logic         w_hb_valid;
  logic [31:0]  w_hb_pc;
  logic [31:0]  w_hb_inst;
  logic         w_req;
  logic         w_hs;
  logic         w_resp;
  logic         w_resp_keep;
  logic         w_load_out;
  logic         w_load_hb;
  logic         w_drain;
  logic         w_hb_to_out;

  // A full hold buffer means both slots are occupied, so no new request may issue.
  assign w_req       = resetn && (r_state == S_REQ) && !w_hb_valid;
  assign w_hs        = w_req && inst_sram_addr_ok;
  assign w_resp      = (r_state == S_WAIT) && inst_sram_data_ok;
  assign w_resp_keep = w_resp && !r_cancel_pend && !br_taken;
  assign w_load_out  = w_resp_keep && (!r_fs_valid || ds_allow_in);
  assign w_load_hb   = w_resp_keep && r_fs_valid && !ds_allow_in;
  assign w_drain     = ds_allow_in && r_fs_valid && !w_resp_keep && !br_taken;
  assign w_hb_to_out = w_drain && w_hb_valid;

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .resetn  (resetn),
    .i_flush (br_taken),
    .i_load  (w_load_hb),
    .i_pc    (r_inflight_pc),
    .i_inst  (inst_sram_rdata),
    .i_drain (w_hb_to_out),
    .o_valid (w_hb_valid),
    .o_pc    (w_hb_pc),
    .o_inst  (w_hb_inst)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_REQ;
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= RESET_PC;
      r_cancel_pend <= 1'b0;
      r_fs_valid    <= 1'b0;
      r_fs_pc       <= RESET_PC;
      r_fs_inst     <= 32'h0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_hs) begin
            r_state       <= S_WAIT;
            r_inflight_pc <= r_fetch_pc;
            r_cancel_pend <= br_taken;
          end
        end
        S_WAIT: begin
          // Any response ends the wait; a pending cancel is consumed by it.
          if (inst_sram_data_ok) begin
            r_state       <= S_REQ;
            r_cancel_pend <= 1'b0;
          end else if (br_taken) begin
            r_cancel_pend <= 1'b1;
          end
        end
        default: r_state <= S_REQ;
      endcase

      if (br_taken) begin
        r_fetch_pc <= br_target;
      end else if (w_hs) begin
        r_fetch_pc <= pc_advance(r_fetch_pc, PC_STEP);
      end

      if (br_taken) begin
        r_fs_valid <= 1'b0;
      end else if (w_load_out) begin
        r_fs_valid <= 1'b1;
        r_fs_pc    <= r_inflight_pc;
        r_fs_inst  <= inst_sram_rdata;
      end else if (w_hb_to_out) begin
        r_fs_valid <= 1'b1;
        r_fs_pc    <= w_hb_pc;
        r_fs_inst  <= w_hb_inst;
      end else if (w_drain) begin
        r_fs_valid <= 1'b0;
      end
    end
  end

  assign inst_sram_req  = w_req;
  assign inst_sram_addr = r_fetch_pc;
  assign fs_valid       = r_fs_valid;
  assign fs_pc          = r_fs_pc;
  assign fs_inst        = r_fs_inst;

`ifdef FETCH_PERF_CNT_EN
  logic        w_resp_drop;
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_cancel_cnt;

  assign w_resp_drop = w_resp && !w_resp_keep;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_perf_fetch_cnt  <= 32'h0;
      r_perf_cancel_cnt <= 32'h0;
    end else begin
      if (!br_taken && (w_load_out || w_hb_to_out)) begin
        r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      end
      if (w_resp_drop) begin
        r_perf_cancel_cnt <= r_perf_cancel_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt  = r_perf_fetch_cnt;
  assign perf_cancel_cnt = r_perf_cancel_cnt;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: table-driven streaming runs against an SRAM model with a
// delivery scoreboard, then hand-written redirect and reset sequences.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ds_allow_in;
  logic        req;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_cancel_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk               (clk),
    .resetn            (resetn),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .ds_allow_in       (ds_allow_in),
    .inst_sram_req     (req),
    .inst_sram_addr    (addr),
    .inst_sram_addr_ok (addr_ok),
    .inst_sram_data_ok (data_ok),
    .inst_sram_rdata   (rdata),
    .fs_valid          (fs_valid),
    .fs_pc             (fs_pc),
    .fs_inst           (fs_inst)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_cancel_cnt   (perf_cancel_cnt)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;

  typedef struct {
    int lat;
    int ok_mod;
    int stall_from;
    int stall_len;
    bit rnd;
    int cycles;
  } vec_t;

  item_t sb[$];
  vec_t  vecs[4];

  function automatic logic [31:0] mk_inst(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579bdf;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn      = 1'b0;
    br_taken    = 1'b0;
    br_target   = 32'h0;
    ds_allow_in = 1'b0;
    addr_ok     = 1'b0;
    data_ok     = 1'b0;
    rdata       = 32'h0;
    #1;
    chk("rst_req_low", {31'h0, req}, 32'h0);
    step();
    step();
    chk("rst_fs_valid", {31'h0, fs_valid}, 32'h0);
    chk("rst_fs_pc", fs_pc, RST_PC);
    chk("rst_fs_inst", fs_inst, 32'h0);
    chk("rst_req", {31'h0, req}, 32'h0);
    resetn = 1'b1;
    step();
    sb.delete();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          held;
    int          nheld;
    int          due;
    int          pushed;
    bit          pend;
    bit          pend_start;
    bit          drain;
    logic [31:0] exp_addr;
    logic [31:0] pend_addr;
    item_t       it;
    held     = 0;
    due      = 0;
    pushed   = 0;
    pend     = 1'b0;
    exp_addr = RST_PC;
    pend_addr = 32'h0;
    do_reset();
    for (int cyc = 0; cyc < v.cycles + 40; cyc++) begin
      drain = (cyc >= v.cycles);
      if (drain && !pend && held == 0 && sb.size() == 0) break;
      pend_start = pend;
      data_ok = pend && (cyc == due);
      rdata   = data_ok ? mk_inst(pend_addr) : 32'h0;
      chk("fs_valid_vs_held", {31'h0, fs_valid}, {31'h0, held != 0});
      if (pend_start) chk("no_req_outstanding", {31'h0, req}, 32'h0);
      if (held == 2) chk("no_req_hb_full", {31'h0, req}, 32'h0);
      if (drain) ds_allow_in = 1'b1;
      else if (v.rnd) ds_allow_in = 1'($urandom_range(0, 1));
      else ds_allow_in = !(cyc >= v.stall_from && cyc < v.stall_from + v.stall_len);
      nheld = held;
      if (fs_valid && ds_allow_in) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow: got pc %h with nothing expected", fs_pc);
        end else begin
          it = sb.pop_front();
          chk("deliver_pc", fs_pc, it.pc);
          chk("deliver_inst", fs_inst, it.inst);
          $display("vec%0d deliver pc=%h inst=%h", idx, fs_pc, fs_inst);
        end
        nheld--;
      end
      if (data_ok) begin
        pend = 1'b0;
        nheld++;
      end
      addr_ok = !drain && (cyc % v.ok_mod == 0);
      if (req && addr_ok) begin
        chk("req_addr", addr, exp_addr);
        it.pc   = exp_addr;
        it.inst = mk_inst(exp_addr);
        sb.push_back(it);
        pushed++;
        pend      = 1'b1;
        pend_addr = addr;
        due       = cyc + v.lat;
        exp_addr  = exp_addr + 32'd4;
      end
      held = nheld;
      step();
    end
    chk("drain_sb_empty", sb.size(), 32'h0);
    chk("drain_no_pend", {31'h0, pend}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_stream", perf_fetch_cnt, pushed);
    chk("perf_cancel_stream", perf_cancel_cnt, 32'h0);
`endif
    $display("vec%0d done lat=%0d pushed=%0d", idx, v.lat, pushed);
    addr_ok     = 1'b0;
    data_ok     = 1'b0;
    ds_allow_in = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{lat: 1, ok_mod: 1, stall_from: 0, stall_len: 0, rnd: 1'b0, cycles: 20};
    vecs[1] = '{lat: 1, ok_mod: 1, stall_from: 6, stall_len: 5, rnd: 1'b0, cycles: 24};
    vecs[2] = '{lat: 3, ok_mod: 2, stall_from: 4, stall_len: 6, rnd: 1'b0, cycles: 30};
    vecs[3] = '{lat: 2, ok_mod: 1, stall_from: 0, stall_len: 0, rnd: 1'b1, cycles: 40};

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Redirect while waiting; the response three cycles after the handshake is dropped.
    do_reset();
    ds_allow_in = 1'b1;
    chk("t3_req0", {31'h0, req}, 32'h1);
    chk("t3_addr0", addr, RST_PC);
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    chk("t3_wait_req", {31'h0, req}, 32'h0);
    br_taken = 1'b1; br_target = 32'h1c000100; step(); br_taken = 1'b0;
    chk("t3_wait_req2", {31'h0, req}, 32'h0);
    step();
    data_ok = 1'b1; rdata = 32'hbad00001; step(); data_ok = 1'b0;
    chk("t3_dropped_valid", {31'h0, fs_valid}, 32'h0);
    chk("t3_redirect_req", {31'h0, req}, 32'h1);
    chk("t3_redirect_addr", addr, 32'h1c000100);
`ifdef FETCH_PERF_CNT_EN
    chk("t3_perf_cancel", perf_cancel_cnt, 32'd1);
`endif
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    data_ok = 1'b1; rdata = 32'h00001111; step(); data_ok = 1'b0;
    chk("t3_fs_valid", {31'h0, fs_valid}, 32'h1);
    chk("t3_fs_pc", fs_pc, 32'h1c000100);
    chk("t3_fs_inst", fs_inst, 32'h00001111);
    $display("t3 redirect in S_WAIT pc=%h", fs_pc);

    // Redirect coincident with data_ok while the output slot is held full.
    ds_allow_in = 1'b0;
    chk("t4_addr", addr, 32'h1c000104);
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    data_ok = 1'b1; rdata = 32'hbad00002; br_taken = 1'b1; br_target = 32'h1c000200;
    step();
    data_ok = 1'b0; br_taken = 1'b0;
    chk("t4_fs_valid", {31'h0, fs_valid}, 32'h0);
    chk("t4_req", {31'h0, req}, 32'h1);
    chk("t4_addr_target", addr, 32'h1c000200);
    $display("t4 redirect with data_ok addr=%h", addr);
    ds_allow_in = 1'b1;

    // Redirect coincident with the handshake; the following response is dropped.
    addr_ok = 1'b1; br_taken = 1'b1; br_target = 32'h1c000300; step();
    addr_ok = 1'b0; br_taken = 1'b0;
    chk("t5_wait_req", {31'h0, req}, 32'h0);
    data_ok = 1'b1; rdata = 32'hbad00003; step(); data_ok = 1'b0;
    chk("t5_fs_valid", {31'h0, fs_valid}, 32'h0);
    chk("t5_req", {31'h0, req}, 32'h1);
    chk("t5_addr", addr, 32'h1c000300);
`ifdef FETCH_PERF_CNT_EN
    chk("t5_perf_cancel", perf_cancel_cnt, 32'd3);
`endif
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    data_ok = 1'b1; rdata = 32'h00003333; step(); data_ok = 1'b0;
    chk("t5_fs_valid2", {31'h0, fs_valid}, 32'h1);
    chk("t5_fs_pc", fs_pc, 32'h1c000300);
    chk("t5_fs_inst", fs_inst, 32'h00003333);
    $display("t5 redirect with handshake pc=%h", fs_pc);

    // Reset while waiting, then a stray response that must be ignored.
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    resetn = 1'b0; #1;
    chk("t6_rst_req", {31'h0, req}, 32'h0);
    step();
    resetn = 1'b1; data_ok = 1'b1; rdata = 32'hbad00004; step(); data_ok = 1'b0;
    chk("t6_fs_valid", {31'h0, fs_valid}, 32'h0);
    chk("t6_req", {31'h0, req}, 32'h1);
    chk("t6_addr", addr, RST_PC);
    chk("t6_fs_pc", fs_pc, RST_PC);
    addr_ok = 1'b1; step(); addr_ok = 1'b0;
    chk("t6_fs_valid_wait", {31'h0, fs_valid}, 32'h0);
    data_ok = 1'b1; rdata = 32'h00006666; step(); data_ok = 1'b0;
    chk("t6_fs_valid2", {31'h0, fs_valid}, 32'h1);
    chk("t6_fs_pc2", fs_pc, RST_PC);
    chk("t6_fs_inst", fs_inst, 32'h00006666);
`ifdef FETCH_PERF_CNT_EN
    chk("t6_perf_fetch", perf_fetch_cnt, 32'd1);
`endif
    $display("t6 reset mid-wait pc=%h", fs_pc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
